// File: rtl/sa_os_seq_ctrl_if.sv
// Handshake/bus bundle between the job/DMA front-end and the systolic-array sequencer.
//   start, k_len          job request and its accumulation length (front-end -> sequencer)
//   src_ready, out_ready  operand-source and result-sink readiness (front-end -> sequencer)
//   busy, done, err       job status (sequencer -> front-end)
//   pe_clr, pe_en         PE accumulator clear and global grid enable
//   feed_vld, k_idx       operand fetch strobe and fetch index
//   row_vld, col_vld      skewed operand valids per PE row / column
//   out_valid, drain_row  result drain strobe and selected PE row
interface sa_os_seq_ctrl_if #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned KW   = 16
);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic            start;
  logic [KW-1:0]   k_len;
  logic            src_ready;
  logic            out_ready;
  logic            busy;
  logic            done;
  logic            err;
  logic            pe_clr;
  logic            pe_en;
  logic            feed_vld;
  logic [KW-1:0]   k_idx;
  logic [ROWS-1:0] row_vld;
  logic [COLS-1:0] col_vld;
  logic            out_valid;
  logic [RW-1:0]   drain_row;

  // Front-end side
  modport master (
    output start, k_len, src_ready, out_ready,
    input  busy, done, err, pe_clr, pe_en, feed_vld, k_idx,
           row_vld, col_vld, out_valid, drain_row
  );

  // Sequencer side
  modport slave (
    input  start, k_len, src_ready, out_ready,
    output busy, done, err, pe_clr, pe_en, feed_vld, k_idx,
           row_vld, col_vld, out_valid, drain_row
  );
endinterface

// File: rtl/sa_os_seq_ctrl.sv
// Sequencer for an output-stationary systolic array of MAC PEs.
// Per job: clear accumulators, issue k_len skewed operand fetches (stalling the grid
// on source back-pressure), wait for the wavefront to flush, then drain rows.
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous reset, active high (aborts any job, no done pulse)
//   bus  sa_os_seq_ctrl_if.slave: job request in, PE control and drain strobes out
// feed_vld, pe_en, row_vld[0] and col_vld[0] follow src_ready in the same cycle;
// every other output comes straight from a register.
// Requires ROWS+COLS-2+PE_LAT >= 1.
module sa_os_seq_ctrl #(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned KW     = 16,
  parameter int unsigned PE_LAT = 1
) (
  input logic             CLK,
  input logic             RST,
  sa_os_seq_ctrl_if.slave bus
);
  localparam int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned FLUSH_CYC = ROWS + COLS - 2 + PE_LAT;
  localparam int unsigned FW        = $clog2(FLUSH_CYC + 1);
  localparam int unsigned SH        = (ROWS > COLS) ? ROWS : COLS;
  localparam int unsigned SHW       = (SH > 1) ? SH - 1 : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t          state;
  logic            busy_q, done_q, err_q, pe_clr_q, out_valid_q;
  logic [RW-1:0]   drain_row_q;
  logic [KW-1:0]   k_idx_q, k_len_q;
  logic [FW-1:0]   flush_cnt_q;
  logic [SHW-1:0]  skew_q;

  logic            feed_vld_c, pe_en_c, last_fetch_c;
  logic [SHW:0]    chain_c;

  // Fetch strobe and grid enable follow the source handshake directly
  assign feed_vld_c   = (state == S_FEED) && bus.src_ready;
  assign pe_en_c      = (state == S_CLEAR) || (state == S_FLUSH) || feed_vld_c;
  assign last_fetch_c = (k_idx_q == k_len_q - KW'(1));

  // One shared delay line: bit i is feed_vld delayed by i enabled cycles
  assign chain_c = {skew_q, feed_vld_c};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pe_clr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      drain_row_q <= '0;
      k_idx_q     <= '0;
      k_len_q     <= '0;
      flush_cnt_q <= '0;
      skew_q      <= '0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      pe_clr_q <= 1'b0;

      // Skew registers freeze with the grid
      if (pe_en_c) skew_q <= chain_c[SHW-1:0];

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.k_len != '0) begin
              k_len_q  <= bus.k_len;
              busy_q   <= 1'b1;
              pe_clr_q <= 1'b1;
              state    <= S_CLEAR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          k_idx_q <= '0;
          state   <= S_FEED;
        end
        S_FEED: begin
          // Compare against k_len-1 so k_len = 2^KW-1 never wraps the index
          if (bus.src_ready) begin
            if (last_fetch_c) begin
              k_idx_q     <= '0;
              flush_cnt_q <= '0;
              state       <= S_FLUSH;
            end else begin
              k_idx_q <= k_idx_q + KW'(1);
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == FW'(FLUSH_CYC - 1)) begin
            out_valid_q <= 1'b1;
            drain_row_q <= '0;
            state       <= S_DRAIN;
          end else begin
            flush_cnt_q <= flush_cnt_q + FW'(1);
          end
        end
        S_DRAIN: begin
          if (bus.out_ready) begin
            if (drain_row_q == RW'(ROWS - 1)) begin
              out_valid_q <= 1'b0;
              drain_row_q <= '0;
              done_q      <= 1'b1;
              state       <= S_DONE;
            end else begin
              drain_row_q <= drain_row_q + RW'(1);
            end
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.pe_clr    = pe_clr_q;
  assign bus.pe_en     = pe_en_c;
  assign bus.feed_vld  = feed_vld_c;
  assign bus.k_idx     = k_idx_q;
  assign bus.row_vld   = chain_c[ROWS-1:0];
  assign bus.col_vld   = chain_c[COLS-1:0];
  assign bus.out_valid = out_valid_q;
  assign bus.drain_row = drain_row_q;
endmodule
